osc_slot_sequencer: RTL and testbench

Time-multiplexing scheduler for the oscillator/envelope datapath. It generates the slot index `xxxx` that walks every voice, oscillator and envelope slot once per frame. It also owns the per-voice phase-reset (`osc_accum_zero`) requests raised by key-on events and applies each request only during a complete visit of the target voice. It sits between the key/voice allocator and the `osc`/`nco2` datapath, clocked on the envelope-rate slot clock.

---
 rtl/osc_slot_sequencer.sv | 86 ++++++++
 tb/tb_osc_slot_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/osc_slot_sequencer.sv
// Slot scheduler for the oscillator/envelope datapath: walks {vx, ox, ex} once per frame and
// applies per-voice phase-reset requests only across a complete visit of the target voice.
module osc_slot_sequencer #(
    parameter int unsigned VOICES   = 8,
    parameter int unsigned V_OSC    = 8,
    parameter int unsigned O_ENVS   = 2,
    parameter int unsigned V_WIDTH  = 3,
    parameter int unsigned O_WIDTH  = 3,
    parameter int unsigned OE_WIDTH = 1,
    parameter int unsigned E_WIDTH  = O_WIDTH + OE_WIDTH,
    parameter int unsigned V_ENVS   = O_ENVS * V_OSC
) (
    input  logic                       sCLK_XVXENVS,
    input  logic                       reset_data_N,
    input  logic                       run,
    output logic [V_WIDTH+E_WIDTH-1:0] xxxx,
    output logic                       osc_tick,
    output logic                       frame_start,
    output logic                       frame_end,
    input  logic                       key_on_req,
    input  logic [V_WIDTH-1:0]         key_on_voice,
    input  logic [V_OSC-1:0]           key_on_mask,
    output logic                       key_on_ack,
    output logic [V_ENVS-1:0]          osc_accum_zero
);

    localparam int unsigned S_WIDTH = V_WIDTH + E_WIDTH;

    logic [S_WIDTH-1:0]           slot_q, slot_d;
    logic [VOICES-1:0][V_OSC-1:0] pend_q, pend_d;
    logic                         ack_q, ack_d;
    logic [V_WIDTH-1:0]           vx;
    logic                         voice_last;
    logic                         accept;

    assign vx         = slot_q[S_WIDTH-1 -: V_WIDTH];
    assign voice_last = &slot_q[E_WIDTH-1:0];

    // The voice under scan is locked out so a visit never sees a mask change part-way through;
    // a held request is also blocked during its own ack cycle.
    assign accept = key_on_req && !ack_q && (!run || (key_on_voice != vx));

    always_comb begin
        slot_d = '0;
        pend_d = pend_q;
        ack_d  = accept;
        if (run) begin
            slot_d = slot_q + S_WIDTH'(1);
        end
        if (run && voice_last) begin
            pend_d[vx] = '0;
        end
        if (accept) begin
            pend_d[key_on_voice] = pend_d[key_on_voice] | key_on_mask;
        end
    end

    always_ff @(posedge sCLK_XVXENVS or negedge reset_data_N) begin
        if (!reset_data_N) begin
            slot_q <= '0;
            pend_q <= '0;
            ack_q  <= 1'b0;
        end else begin
            slot_q <= slot_d;
            pend_q <= pend_d;
            ack_q  <= ack_d;
        end
    end

    always_comb begin
        xxxx           = slot_q;
        osc_tick       = (slot_q[OE_WIDTH-1:0] == '0);
        frame_start    = run && reset_data_N && (slot_q == '0);
        frame_end      = &slot_q;
        key_on_ack     = ack_q;
        osc_accum_zero = '0;
        if (run) begin
            for (int unsigned o = 0; o < V_OSC; o++) begin
                for (int unsigned e = 0; e < O_ENVS; e++) begin
                    osc_accum_zero[o*O_ENVS+e] = pend_q[vx][o];
                end
            end
        end
    end

endmodule

// File: tb/tb_osc_slot_sequencer.sv
// Directed bench for osc_slot_sequencer: counter, reset, key-on accept/defer/merge, stop/resume.
module tb_osc_slot_sequencer;

    logic        clk = 1'b0;
    logic        reset_data_N;
    logic        run;
    logic [6:0]  xxxx;
    logic        osc_tick;
    logic        frame_start;
    logic        frame_end;
    logic        key_on_req;
    logic [2:0]  key_on_voice;
    logic [7:0]  key_on_mask;
    logic        key_on_ack;
    logic [15:0] osc_accum_zero;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    osc_slot_sequencer dut (
        .sCLK_XVXENVS   (clk),
        .reset_data_N   (reset_data_N),
        .run            (run),
        .xxxx           (xxxx),
        .osc_tick       (osc_tick),
        .frame_start    (frame_start),
        .frame_end      (frame_end),
        .key_on_req     (key_on_req),
        .key_on_voice   (key_on_voice),
        .key_on_mask    (key_on_mask),
        .key_on_ack     (key_on_ack),
        .osc_accum_zero (osc_accum_zero)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_slot(input int target);
        int n = 0;
        do begin
            step();
            n++;
        end while (int'(xxxx) != target && n < 300);
        if (int'(xxxx) != target) begin
            checks++;
            $display("FAIL wait_slot: xxxx=%0d required %0d", xxxx, target);
        end
    endtask

    task automatic test_reset();
        int n;
        reset_data_N = 1'b0;
        run          = 1'b1;
        key_on_req   = 1'b0;
        key_on_voice = '0;
        key_on_mask  = '0;
        #2;
        checks++; if (xxxx !== 7'd0) $display("FAIL rst_xxxx: got %0d want 0", xxxx); else passes++;
        checks++; if (osc_tick !== 1'b1) $display("FAIL rst_tick: got %b want 1", osc_tick); else passes++;
        checks++; if (frame_start !== 1'b0) $display("FAIL rst_fs: got %b want 0", frame_start); else passes++;
        repeat (2) @(posedge clk);
        #1 reset_data_N = 1'b1;
        step();
        checks++; if (xxxx !== 7'd1) $display("FAIL rel_count: got %0d want 1", xxxx); else passes++;
        wait_slot(3);
        key_on_req = 1'b1; key_on_voice = 3'd1; key_on_mask = 8'hFF;
        step();
        checks++; if (key_on_ack !== 1'b1) $display("FAIL pre_ack: got %b want 1", key_on_ack); else passes++;
        key_on_req = 1'b0;
        wait_slot(20);
        checks++; if (osc_accum_zero !== 16'hFFFF) $display("FAIL pre_zero: got %h want ffff", osc_accum_zero); else passes++;
        #3 reset_data_N = 1'b0;
        #1;
        checks++; if (xxxx !== 7'd0) $display("FAIL mid_rst_xxxx: got %0d want 0", xxxx); else passes++;
        checks++; if (osc_accum_zero !== 16'h0) $display("FAIL mid_rst_zero: got %h want 0", osc_accum_zero); else passes++;
        checks++; if (key_on_ack !== 1'b0) $display("FAIL mid_rst_ack: got %b want 0", key_on_ack); else passes++;
        checks++; if (osc_tick !== 1'b1) $display("FAIL mid_rst_tick: got %b want 1", osc_tick); else passes++;
        checks++; if (frame_start !== 1'b0) $display("FAIL mid_rst_fs: got %b want 0", frame_start); else passes++;
        checks++; if (frame_end !== 1'b0) $display("FAIL mid_rst_fe: got %b want 0", frame_end); else passes++;
        @(posedge clk);
        #1;
        checks++; if (xxxx !== 7'd0) $display("FAIL rst_hold: got %0d want 0", xxxx); else passes++;
        reset_data_N = 1'b1;
        #1;
        checks++; if (frame_start !== 1'b1) $display("FAIL rel_fs: got %b want 1", frame_start); else passes++;
        step();
        checks++; if (xxxx !== 7'd1) $display("FAIL rel_count2: got %0d want 1", xxxx); else passes++;
        n = 1;
        while (frame_start !== 1'b1 && n < 300) begin
            step();
            n++;
        end
        checks++; if (n != 128) $display("FAIL frame_period: got %0d want 128", n); else passes++;
        wait_slot(20);
        checks++; if (osc_accum_zero !== 16'h0) $display("FAIL rst_discard: got %h want 0", osc_accum_zero); else passes++;
    endtask

    task automatic test_basic();
        wait_slot(5);
        key_on_req = 1'b1; key_on_voice = 3'd3; key_on_mask = 8'h05;
        step();
        checks++; if (key_on_ack !== 1'b1) $display("FAIL basic_ack: got %b want 1", key_on_ack); else passes++;
        key_on_req = 1'b0;
        step();
        checks++; if (key_on_ack !== 1'b0) $display("FAIL basic_ack_drop: got %b want 0", key_on_ack); else passes++;
        wait_slot(47);
        checks++; if (osc_accum_zero !== 16'h0) $display("FAIL basic_v2: got %h want 0", osc_accum_zero); else passes++;
        step();
        checks++; if (osc_accum_zero !== 16'h0033) $display("FAIL basic_48: got %h want 0033", osc_accum_zero); else passes++;
        wait_slot(63);
        checks++; if (osc_accum_zero !== 16'h0033) $display("FAIL basic_63: got %h want 0033", osc_accum_zero); else passes++;
        step();
        checks++; if (osc_accum_zero !== 16'h0) $display("FAIL basic_64: got %h want 0", osc_accum_zero); else passes++;
        wait_slot(48);
        checks++; if (osc_accum_zero !== 16'h0) $display("FAIL basic_cleared: got %h want 0", osc_accum_zero); else passes++;
    endtask

    task automatic test_deferral();
        int ack_slot = -1;
        wait_slot(34);
        key_on_req = 1'b1; key_on_voice = 3'd2; key_on_mask = 8'h02;
        for (int i = 0; i < 40; i++) begin
            step();
            if (key_on_ack === 1'b1) begin
                ack_slot = int'(xxxx);
                break;
            end
        end
        checks++; if (ack_slot != 49) $display("FAIL defer_ack_slot: got %0d want 49", ack_slot); else passes++;
        key_on_req = 1'b0;
        step();
        checks++; if (key_on_ack !== 1'b0) $display("FAIL defer_ack_drop: got %b want 0", key_on_ack); else passes++;
        wait_slot(31);
        checks++; if (osc_accum_zero !== 16'h0) $display("FAIL defer_31: got %h want 0", osc_accum_zero); else passes++;
        step();
        checks++; if (osc_accum_zero !== 16'h000C) $display("FAIL defer_32: got %h want 000c", osc_accum_zero); else passes++;
        wait_slot(47);
        checks++; if (osc_accum_zero !== 16'h000C) $display("FAIL defer_47: got %h want 000c", osc_accum_zero); else passes++;
        step();
        checks++; if (osc_accum_zero !== 16'h0) $display("FAIL defer_48: got %h want 0", osc_accum_zero); else passes++;
    endtask

    task automatic test_merge();
        wait_slot(50);
        key_on_req = 1'b1; key_on_voice = 3'd7; key_on_mask = 8'h01;
        step();
        checks++; if (key_on_ack !== 1'b1) $display("FAIL merge_ack1: got %b want 1", key_on_ack); else passes++;
        key_on_mask = 8'h80;
        step();
        checks++; if (key_on_ack !== 1'b0) $display("FAIL merge_ackgap: got %b want 0", key_on_ack); else passes++;
        step();
        checks++; if (key_on_ack !== 1'b1) $display("FAIL merge_ack2: got %b want 1", key_on_ack); else passes++;
        key_on_req = 1'b0;
        wait_slot(111);
        checks++; if (osc_accum_zero !== 16'h0) $display("FAIL merge_111: got %h want 0", osc_accum_zero); else passes++;
        step();
        checks++; if (osc_accum_zero !== 16'hC003) $display("FAIL merge_112: got %h want c003", osc_accum_zero); else passes++;
        checks++; if (frame_end !== 1'b0) $display("FAIL fe_112: got %b want 0", frame_end); else passes++;
        wait_slot(127);
        checks++; if (osc_accum_zero !== 16'hC003) $display("FAIL merge_127: got %h want c003", osc_accum_zero); else passes++;
        checks++; if (frame_end !== 1'b1) $display("FAIL fe_127: got %b want 1", frame_end); else passes++;
        step();
        checks++; if (xxxx !== 7'd0) $display("FAIL wrap: got %0d want 0", xxxx); else passes++;
        checks++; if (frame_start !== 1'b1) $display("FAIL fs_wrap: got %b want 1", frame_start); else passes++;
        checks++; if (osc_accum_zero !== 16'h0) $display("FAIL merge_v0: got %h want 0", osc_accum_zero); else passes++;
        wait_slot(112);
        checks++; if (osc_accum_zero !== 16'h0) $display("FAIL merge_cleared: got %h want 0", osc_accum_zero); else passes++;
    endtask

    task automatic test_held();
        logic exp_ack [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        wait_slot(10);
        key_on_req = 1'b1; key_on_voice = 3'd5; key_on_mask = 8'h10;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (key_on_ack !== exp_ack[i])
                $display("FAIL held_ack%0d: got %b want %b", i, key_on_ack, exp_ack[i]);
            else
                passes++;
            if (i == 3) key_on_req = 1'b0;
        end
        wait_slot(80);
        checks++; if (osc_accum_zero !== 16'h0300) $display("FAIL held_80: got %h want 0300", osc_accum_zero); else passes++;
        wait_slot(95);
        checks++; if (osc_accum_zero !== 16'h0300) $display("FAIL held_95: got %h want 0300", osc_accum_zero); else passes++;
    endtask

    task automatic test_stop();
        step();
        key_on_req = 1'b1; key_on_voice = 3'd4; key_on_mask = 8'h40;
        step();
        checks++; if (key_on_ack !== 1'b1) $display("FAIL stop_ack4: got %b want 1", key_on_ack); else passes++;
        key_on_req = 1'b0;
        wait_slot(100);
        run = 1'b0;
        step();
        checks++; if (xxxx !== 7'd0) $display("FAIL stop_xxxx: got %0d want 0", xxxx); else passes++;
        checks++; if (frame_start !== 1'b0) $display("FAIL stop_fs: got %b want 0", frame_start); else passes++;
        key_on_req = 1'b1; key_on_voice = 3'd0; key_on_mask = 8'h03;
        step();
        checks++; if (key_on_ack !== 1'b1) $display("FAIL stop_ack0: got %b want 1", key_on_ack); else passes++;
        key_on_req = 1'b0;
        repeat (3) step();
        checks++; if (xxxx !== 7'd0) $display("FAIL stop_hold: got %0d want 0", xxxx); else passes++;
        checks++; if (osc_accum_zero !== 16'h0) $display("FAIL stop_zero: got %h want 0", osc_accum_zero); else passes++;
        run = 1'b1;
        #1;
        checks++; if (frame_start !== 1'b1) $display("FAIL resume_fs: got %b want 1", frame_start); else passes++;
        checks++; if (osc_accum_zero !== 16'h000F) $display("FAIL resume_0: got %h want 000f", osc_accum_zero); else passes++;
        step();
        checks++; if (xxxx !== 7'd1) $display("FAIL resume_count: got %0d want 1", xxxx); else passes++;
        wait_slot(15);
        checks++; if (osc_accum_zero !== 16'h000F) $display("FAIL resume_15: got %h want 000f", osc_accum_zero); else passes++;
        step();
        checks++; if (osc_accum_zero !== 16'h0) $display("FAIL resume_16: got %h want 0", osc_accum_zero); else passes++;
        wait_slot(64);
        checks++; if (osc_accum_zero !== 16'h3000) $display("FAIL resume_64: got %h want 3000", osc_accum_zero); else passes++;
        wait_slot(79);
        checks++; if (osc_accum_zero !== 16'h3000) $display("FAIL resume_79: got %h want 3000", osc_accum_zero); else passes++;
        step();
        checks++; if (osc_accum_zero !== 16'h0) $display("FAIL resume_80: got %h want 0", osc_accum_zero); else passes++;
        wait_slot(0);
        checks++; if (osc_accum_zero !== 16'h0) $display("FAIL resume_v0_clr: got %h want 0", osc_accum_zero); else passes++;
        wait_slot(64);
        checks++; if (osc_accum_zero !== 16'h0) $display("FAIL resume_v4_clr: got %h want 0", osc_accum_zero); else passes++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_deferral();
        test_merge();
        test_held();
        test_stop();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
